// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry valid/ready pipeline register with a skid slot.
// The main register drives out_data. The skid register catches the one entry
// that arrives in the cycle downstream stalls, so in_ready can be registered.
module pipe_skid_reg #(
    parameter int                 WIDTH   = 16,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_main;
    logic [WIDTH-1:0]   r_skid;
    logic               r_in_ready;
    logic               r_out_valid;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_main_nxt;
    logic [WIDTH-1:0]   w_skid_nxt;
    logic               w_accept;
    logic               w_consume;

    // Flags any input bit that is neither 0 nor 1; purely an observer.
    function automatic logic f_has_unknown(input logic [WIDTH+3:0] v);
        return $isunknown(v);
    endfunction

    assign w_accept  = in_valid & r_in_ready;
    assign w_consume = r_out_valid & out_ready;

    // Next-state and next-data selection; flush wins over any handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = RST_VAL;
            w_skid_nxt  = RST_VAL;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    case ({w_accept, w_consume})
                        2'b10: begin
                            w_state_nxt = ST_FULL;
                            w_skid_nxt  = in_data;
                        end
                        2'b01: begin
                            w_state_nxt = ST_EMPTY;
                            w_main_nxt  = RST_VAL;
                        end
                        2'b11: begin
                            w_state_nxt = ST_ONE;
                            w_main_nxt  = in_data;
                        end
                        default: begin
                            w_state_nxt = ST_ONE;
                        end
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so only a consume can move us.
                    if (w_consume) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = RST_VAL;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty state.
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = RST_VAL;
                    w_skid_nxt  = RST_VAL;
                end
            endcase
        end
    end

    // State and data registers; handshake flags are registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= RST_VAL;
            r_skid      <= RST_VAL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign err       = f_has_unknown({rst, flush, in_valid, out_ready, in_data});

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: width in bits of the data path.
REQ-002 The block SHALL have parameter RST_VAL, default 0 (WIDTH bits): value driven on out_data whenever the block holds no valid entry.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  block can accept an entry this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 out_data  output  WIDTH  head entry, or RST_VAL when empty.
REQ-012 err  output  1  combinational flag for an unknown or high-impedance value on any input.

Function
REQ-013 The block SHALL hold at most two entries: a main register driving out_data and a skid register.
REQ-014 State encoding SHALL be EMPTY (0 entries), ONE (main only) or FULL (main and skid).
REQ-015 Accept SHALL occur on an edge where in_valid & in_ready = 1; consume SHALL occur on an edge where out_valid & out_ready = 1.
REQ-016 in_ready SHALL be a registered output: 1 in EMPTY and ONE, 0 in FULL.
REQ-017 out_valid SHALL be 1 in ONE and FULL and 0 in EMPTY; out_data SHALL be a registered output.
REQ-018 EMPTY transitions: accept -> ONE with main = in_data; otherwise stay in EMPTY.
REQ-019 ONE transitions: accept with no consume -> FULL, with skid = in_data; consume with no accept -> EMPTY; accept and consume together -> ONE, with main = in_data; neither -> hold.
REQ-020 FULL transitions: consume -> ONE, with main = skid; no consume -> hold; accept is impossible because in_ready = 0.
REQ-021 Latency SHALL be one cycle: data accepted at edge k appears on out_data after edge k when the block was EMPTY, or when it was ONE and consumed at edge k.
REQ-022 Entries SHALL leave in acceptance order, with no loss and no duplication.
REQ-023 With out_ready held at 1, throughput SHALL be one entry per cycle with in_ready constantly 1.
REQ-024 The block SHALL NOT change out_data while out_valid = 1 and out_ready = 0.
REQ-025 flush SHALL move the block to EMPTY at the next edge, set out_data = RST_VAL, out_valid = 0 and in_ready = 1, and discard any same-cycle accept.
REQ-026 A consume that coincides with flush SHALL be counted as taken by downstream.
REQ-027 rst SHALL have priority over flush; flush SHALL have priority over accept and consume.
REQ-028 The err output SHALL be 1 when any bit of rst, flush, in_valid, out_ready or in_data is not 0 or 1.
REQ-029 err SHALL NOT alter state.
REQ-030 The internal skid register SHALL NOT be observable on any output except through main.

Reset
REQ-031 While rst = 1 at an edge, the block SHALL enter EMPTY with out_valid = 0, in_ready = 1, out_data = RST_VAL and skid = RST_VAL.
REQ-032 Reset SHALL take effect regardless of in_valid, out_ready, flush or current state, including mid-transfer in FULL.
REQ-033 The first accept after reset SHALL be possible on the first edge with rst = 0.

Verification
REQ-034 Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles with out_ready = 1 -> out_data shows 0x1111, 0x2222, 0x3333 one cycle later each; in_ready stays 1.
REQ-035 out_ready = 0, push 0xAAAA then 0xBBBB -> in_ready = 0 after the second edge and out_data stays 0xAAAA; then raise out_ready -> 0xAAAA, then 0xBBBB, then out_valid = 0.
REQ-036 In FULL with 0xAAAA/0xBBBB, assert flush with in_valid = 1 and in_data = 0xCCCC -> next cycle out_valid = 0, out_data = RST_VAL, in_ready = 1, and 0xCCCC never appears.
REQ-037 In FULL, assert rst and flush together with in_valid = 1 -> EMPTY and out_data = RST_VAL; the next push of 0x1234 appears after one edge.
REQ-038 Random in_valid/out_ready for 10k cycles against a reference queue model -> order and count match and no accept ever occurs with in_ready = 0.
REQ-039 Drive in_data bit 3 to X -> err = 1 in the same cycle; restore a known value -> err = 0, with held state unchanged.
